halton_fetch_ctrl: RTL and testbench

//  Requester side of the Halton generator pop/valid/reseed interface. Issues single-cycle
//  pop pulses, waits for the generator's valid edge with a timeout/retry policy, and buffers

---
 rtl/halton_fetch_pkg.sv | 19 +
 rtl/halton_sample_fifo.sv | 64 ++++++
 rtl/halton_fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_halton_fetch_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halton_fetch_pkg.sv
// Shared types and sizing helpers for the Halton sample fetch controller.
package halton_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RESEED = 3'd1,
        POP    = 3'd2,
        WAIT   = 3'd3,
        ERR    = 3'd4
    } fetch_state_t;

    localparam int HF_WIDTH = 32;

    // Counter width able to hold 0 .. cycles-1, never narrower than one bit.
    function automatic int to_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/halton_sample_fifo.sv
// Synchronous sample-pair FIFO with flush; read data is the head entry, no read latency.
// Pushes when full and pops when empty are dropped; flush wins over push and pop.
module halton_sample_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [DW-1:0]    push_dat_i,
    input  logic             pop_i,
    output logic [DW-1:0]    rd_dat_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o   = (level_q == LVL_W'(DEPTH));
    assign empty_o  = (level_q == '0);
    assign do_push  = push_i & ~full_o;
    assign do_pop   = pop_i & ~empty_o;
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign level_o  = level_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/halton_fetch_ctrl.sv
// Requester for the Halton generator: pop/timeout/retry FSM, reseed sequencing, sample buffering.
// Pop issues one cycle after IDLE; push lands on the valid-edge cycle; m_valid follows a cycle later.
module halton_fetch_ctrl
    import halton_fetch_pkg::*;
#(
    parameter int WIDTH          = HF_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int MAX_RETRIES    = 2,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             reseed_req,
    input  logic [31:0]      reseed_value,
    output logic             pop_enable,
    output logic [31:0]      seed,
    output logic             reseed_enable,
    input  logic [WIDTH-1:0] gen_out_0,
    input  logic [WIDTH-1:0] gen_out_1,
    input  logic             gen_valid,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data_0,
    output logic [WIDTH-1:0] m_data_1,
    output logic [LVL_W-1:0] fifo_level,
    output logic             busy,
    output logic             timeout_err,
    output logic [15:0]      timeout_count
);

    localparam int TO_W = to_cnt_w(TIMEOUT_CYCLES);
    localparam int RT_W = to_cnt_w(MAX_RETRIES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);

    fetch_state_t    state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic [RT_W-1:0] retry_q, retry_d;
    logic            gen_valid_q;
    logic            rs_pend_q, rs_pend_d;
    logic [31:0]     rs_val_q, rs_val_d;
    logic [31:0]     seed_q, seed_d;
    logic            terr_q, terr_d;
    logic [15:0]     tcnt_q, tcnt_d;

    logic            edge_det;
    logic            rs_any;
    logic [31:0]     rs_seed;
    logic            push;
    logic            flush;
    logic            fifo_full;
    logic            fifo_empty;
    logic [2*WIDTH-1:0] head_dat;

    assign edge_det = gen_valid & ~gen_valid_q;
    // A request seen this very cycle counts as pending, with its value taking precedence.
    assign rs_any   = rs_pend_q | reseed_req;
    assign rs_seed  = reseed_req ? reseed_value : rs_val_q;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        retry_d       = retry_q;
        seed_d        = seed_q;
        terr_d        = terr_q;
        tcnt_d        = tcnt_q;
        rs_pend_d     = rs_pend_q | reseed_req;
        rs_val_d      = rs_seed;
        push          = 1'b0;
        flush         = 1'b0;
        pop_enable    = 1'b0;
        reseed_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (rs_any) begin
                    state_d = RESEED;
                    seed_d  = rs_seed;
                end else if (enable && !fifo_full) begin
                    state_d = POP;
                end
            end
            RESEED: begin
                reseed_enable = 1'b1;
                flush         = 1'b1;
                terr_d        = 1'b0;
                retry_d       = '0;
                rs_pend_d     = reseed_req;
                state_d       = IDLE;
            end
            POP: begin
                pop_enable = 1'b1;
                wait_d     = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (edge_det) begin
                    push    = 1'b1;
                    retry_d = '0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == TO_LAST) begin
                        tcnt_d = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
                        if (retry_q < RT_MAX) begin
                            retry_d = retry_q + 1'b1;
                            state_d = POP;
                        end else begin
                            terr_d  = 1'b1;
                            state_d = ERR;
                        end
                    end
                end
            end
            ERR: begin
                if (rs_any) begin
                    state_d = RESEED;
                    seed_d  = rs_seed;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            retry_q     <= '0;
            gen_valid_q <= 1'b0;
            rs_pend_q   <= 1'b0;
            rs_val_q    <= '0;
            seed_q      <= '0;
            terr_q      <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            retry_q     <= retry_d;
            gen_valid_q <= gen_valid;
            rs_pend_q   <= rs_pend_d;
            rs_val_q    <= rs_val_d;
            seed_q      <= seed_d;
            terr_q      <= terr_d;
            tcnt_q      <= tcnt_d;
        end
    end

    halton_sample_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .push_i     (push),
        .push_dat_i ({gen_out_0, gen_out_1}),
        .pop_i      (m_ready),
        .rd_dat_o   (head_dat),
        .level_o    (fifo_level),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign m_valid       = ~fifo_empty;
    assign m_data_0      = head_dat[2*WIDTH-1:WIDTH];
    assign m_data_1      = head_dat[WIDTH-1:0];
    assign seed          = seed_q;
    assign busy          = (state_q != IDLE);
    assign timeout_err   = terr_q;
    assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_halton_fetch_ctrl.sv
// Bench for halton_fetch_ctrl: responder model, per-cycle scoreboard and directed scenarios.
module tb_halton_fetch_ctrl;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst, enable, reseed_req, gen_valid, m_ready;
    logic [31:0] reseed_value, seed;
    logic [W-1:0] gen_out_0, gen_out_1, m_data_0, m_data_1;
    logic        pop_enable, reseed_enable, m_valid, busy, timeout_err;
    logic [2:0]  fifo_level;
    logic [15:0] timeout_count;

    always #5 clk = ~clk;

    halton_fetch_ctrl #(.WIDTH(W), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .reseed_req(reseed_req), .reseed_value(reseed_value),
        .pop_enable(pop_enable), .seed(seed), .reseed_enable(reseed_enable),
        .gen_out_0(gen_out_0), .gen_out_1(gen_out_1), .gen_valid(gen_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data_0(m_data_0), .m_data_1(m_data_1),
        .fifo_level(fifo_level), .busy(busy), .timeout_err(timeout_err), .timeout_count(timeout_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responder: answers each pop N cycles later with the next queued pair (or a default pattern).
    bit          resp_on  = 1'b1;
    int          resp_n   = 3;
    int          fire_req = 0;
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];

    initial begin
        int cd = 0;
        int fire_seen = 0;
        int dflt = 0;
        bit fire;
        gen_valid = 1'b0;
        gen_out_0 = '0;
        gen_out_1 = '0;
        forever begin
            @(posedge clk);
            #1;
            gen_valid = 1'b0;
            fire = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) fire = 1'b1;
            end
            if (fire_req != fire_seen) begin
                fire_seen = fire_req;
                fire = 1'b1;
            end
            if (fire) begin
                gen_valid = 1'b1;
                if (rq0.size() != 0) begin
                    gen_out_0 = rq0.pop_front();
                    gen_out_1 = rq1.pop_front();
                end else begin
                    gen_out_0 = 32'hC000_0000 + dflt;
                    gen_out_1 = 32'h0000_1000 + dflt;
                    dflt++;
                end
            end
            if (pop_enable && resp_on) cd = resp_n;
        end
    end

    // Scoreboard: a request is live for TO cycles after its pop; a fresh valid edge
    // within that window is a sample, anything else is ignored.
    logic [63:0] exp_q[$];
    logic [63:0] dlv_log[$];
    int pops    = 0;
    int reseeds = 0;

    initial begin
        bit outst = 1'b0;
        int age = 0;
        bit prev_v = 1'b0;
        int lvl0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                outst  = 1'b0;
                prev_v = 1'b0;
            end else begin
                lvl0 = exp_q.size();
                check("m_valid", {63'b0, m_valid}, {63'b0, lvl0 != 0});
                check("fifo_level", 64'(fifo_level), 64'(lvl0));
                if (lvl0 != 0) begin
                    check("m_data", {m_data_0, m_data_1}, exp_q[0]);
                    if (m_ready) begin
                        dlv_log.push_back({m_data_0, m_data_1});
                        void'(exp_q.pop_front());
                    end
                end
                if (reseed_enable) begin
                    reseeds++;
                    exp_q.delete();
                end
                if (outst) begin
                    age++;
                    if (gen_valid && !prev_v) begin
                        exp_q.push_back({gen_out_0, gen_out_1});
                        outst = 1'b0;
                    end else if (age == TO) begin
                        outst = 1'b0;
                    end
                end
                if (pop_enable) begin
                    check("pop_legal", {63'b0, !outst && lvl0 < D}, 64'd1);
                    pops++;
                    outst = 1'b1;
                    age = 0;
                end
                prev_v = gen_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1, d0, r0, k, seen, t;
        int pt[$];
        rst = 1'b1; enable = 1'b0; reseed_req = 1'b0; reseed_value = '0; m_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_pop", {63'b0, pop_enable}, 0);
        check("rst_reseed_en", {63'b0, reseed_enable}, 0);
        check("rst_seed", 64'(seed), 0);
        check("rst_mvalid", {63'b0, m_valid}, 0);
        check("rst_level", 64'(fifo_level), 0);
        check("rst_busy", {63'b0, busy}, 0);
        check("rst_terr", {63'b0, timeout_err}, 0);
        check("rst_tcnt", 64'(timeout_count), 0);
        check("rst_mdata", {m_data_0, m_data_1}, 0);

        // 1: two pairs, latency pinned
        rq0.push_back(32'h8000_0000); rq1.push_back(32'h5555_5555);
        rq0.push_back(32'h4000_0000); rq1.push_back(32'hAAAA_AAAA);
        resp_n = 3; m_ready = 1'b1; p0 = pops; d0 = dlv_log.size();
        enable = 1'b1;
        tick(); check("t1_pop_latency", {63'b0, pop_enable}, 1);
        repeat (3) tick(); check("t1_mvalid_on_push_cycle", {63'b0, m_valid}, 0);
        tick(); check("t1_mvalid_rise", {63'b0, m_valid}, 1);
        k = 0;
        while (!pop_enable && k < 20) begin tick(); k++; end
        check("t1_second_pop", {63'b0, pop_enable}, 1);
        enable = 1'b0;
        repeat (12) tick();
        check("t1_pops", 64'(pops - p0), 2);
        check("t1_delivered", 64'(dlv_log.size() - d0), 2);
        if (dlv_log.size() >= d0 + 2) begin
            check("t1_pair0", dlv_log[d0], 64'h8000_0000_5555_5555);
            check("t1_pair1", dlv_log[d0 + 1], 64'h4000_0000_AAAA_AAAA);
        end

        // 2: fill under backpressure, then drain
        m_ready = 1'b0; resp_n = 2; p0 = pops; enable = 1'b1;
        repeat (40) tick();
        check("t2_fill_pops", 64'(pops - p0), 4);
        check("t2_full_level", 64'(fifo_level), 4);
        check("t2_idle_when_full", {63'b0, busy}, 0);
        check("t2_head", {m_data_0, m_data_1}, 64'hC000_0000_0000_1000);
        d0 = dlv_log.size(); p1 = pops;
        m_ready = 1'b1;
        tick(); check("t2_lvl3", 64'(fifo_level), 3);
        tick(); check("t2_lvl2", 64'(fifo_level), 2);
        check("t2_refill_pop", {63'b0, pop_enable}, 1);
        tick(); check("t2_lvl1", 64'(fifo_level), 1);
        enable = 1'b0;
        repeat (10) tick();
        check("t2_drained", 64'(fifo_level), 0);
        check("t2_refills", 64'(pops - p1), 1);
        check("t2_delivered", 64'(dlv_log.size() - d0), 5);

        // 3: silent responder -> two retries then ERR
        resp_on = 1'b0; p0 = pops; t = 0; enable = 1'b1;
        while (pt.size() < 3 && t < 400) begin
            tick(); t++;
            if (pop_enable) pt.push_back(t);
        end
        check("t3_pop_count", 64'(pt.size()), 3);
        if (pt.size() == 3) begin
            check("t3_gap1", 64'(pt[1] - pt[0]), 101);
            check("t3_gap2", 64'(pt[2] - pt[1]), 101);
        end
        repeat (110) tick();
        check("t3_terr", {63'b0, timeout_err}, 1);
        check("t3_tcnt", 64'(timeout_count), 3);
        check("t3_busy_err", {63'b0, busy}, 1);
        check("t3_no_more_pops", 64'(pops - p0), 3);
        fire_req++;
        repeat (5) tick();
        check("t3_late_ignored", 64'(fifo_level), 0);
        resp_on = 1'b1;

        // 4: exit ERR by reseed, then a reseed deferred across an outstanding request
        r0 = reseeds;
        reseed_value = 32'h1234_5678; reseed_req = 1'b1;
        tick(); reseed_req = 1'b0; reseed_value = '0;
        check("t4_err_reseed_pulse", {63'b0, reseed_enable}, 1);
        check("t4_err_seed", 64'(seed), 64'h1234_5678);
        tick();
        check("t4_pulse_once", {63'b0, reseed_enable}, 0);
        check("t4_terr_cleared", {63'b0, timeout_err}, 0);
        check("t4_tcnt_kept", 64'(timeout_count), 3);
        m_ready = 1'b0; resp_n = 5; seen = 0; k = 0;
        while (seen < 2 && k < 50) begin
            tick(); k++;
            if (pop_enable) seen++;
        end
        check("t4_two_pops", 64'(seen), 2);
        tick(); enable = 1'b0; reseed_value = 32'hDEAD_BEEF; reseed_req = 1'b1;
        tick(); reseed_req = 1'b0; reseed_value = '0;
        check("t4_deferred", {63'b0, reseed_enable}, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); check("t4_deferred", {63'b0, reseed_enable}, 0);
        end
        check("t4_level_before", 64'(fifo_level), 2);
        tick();
        check("t4_reseed_pulse", {63'b0, reseed_enable}, 1);
        check("t4_seed", 64'(seed), 64'hDEAD_BEEF);
        tick();
        check("t4_pulse_once2", {63'b0, reseed_enable}, 0);
        check("t4_flushed", {63'b0, m_valid}, 0);
        check("t4_seed_held", 64'(seed), 64'hDEAD_BEEF);
        check("t4_reseed_count", 64'(reseeds - r0), 2);

        // 5: push and stream pop in the same cycle at level 2
        resp_n = 3; seen = 0; k = 0; enable = 1'b1;
        while (seen < 3 && k < 60) begin
            tick(); k++;
            if (pop_enable) seen++;
        end
        enable = 1'b0;
        repeat (3) tick();
        check("t5_level_before", 64'(fifo_level), 2);
        m_ready = 1'b1;
        tick(); m_ready = 1'b0;
        check("t5_level_same", 64'(fifo_level), 2);
        m_ready = 1'b1;
        repeat (5) tick();
        check("t5_drained", 64'(fifo_level), 0);

        // rst in WAIT with an entry buffered and an answer still on its way
        m_ready = 1'b0; resp_n = 5; seen = 0; k = 0; enable = 1'b1;
        while (seen < 2 && k < 60) begin
            tick(); k++;
            if (pop_enable) seen++;
        end
        tick(); rst = 1'b1; enable = 1'b0;
        tick(); rst = 1'b0;
        check("rst2_pop", {63'b0, pop_enable}, 0);
        check("rst2_seed", 64'(seed), 0);
        check("rst2_mvalid", {63'b0, m_valid}, 0);
        check("rst2_level", 64'(fifo_level), 0);
        check("rst2_busy", {63'b0, busy}, 0);
        check("rst2_tcnt", 64'(timeout_count), 0);
        repeat (8) tick();
        check("rst2_inflight_ignored", 64'(fifo_level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
